aes_key_expansion: RTL and testbench

Iterative AES key schedule that sits directly upstream of aes_decryption and aes_encryption. It accepts a 128- or 256-bit cipher key and computes one 128-bit round key per clock. All round keys are stored in an internal register file. The cipher core reads any round key by index, so decryption can walk the schedule in reverse with no recomputation.

---
 rtl/aes_key_expansion.sv | 151 +++++++++++++++
 tb/tb_aes_key_expansion.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expansion.sv
// Iterative AES-128/AES-256 key schedule: one round key per clock into a
// register file that the cipher cores read by index.
module aes_key_expansion #(
    parameter int MAX_RK   = 15,
    parameter int RK_IDX_W = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                key_init,
    input  logic                keylen,
    input  logic [255:0]        key,
    input  logic [RK_IDX_W-1:0] round,
    output logic [127:0]        round_key,
    output logic                key_ready,
    output logic [RK_IDX_W-1:0] num_rounds
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t                state_r, state_nxt_s;
    logic [127:0]          storage_r [0:MAX_RK-1];
    logic [127:0]          prev1_r, prev2_r;
    logic [RK_IDX_W-1:0]   cnt_r, nr_r;
    logic                  len_r, key_ready_r;
    logic [31:0]           t_s, w0_s, w1_s, w2_s, w3_s;
    logic [127:0]          base_s, new_rk_s;
    logic [3:0]            rc_idx_s;

    // Next round key from the held operands; AES-256 chains off rk_{n-2}.
    always_comb begin
        t_s      = 32'h0;
        rc_idx_s = 4'(len_r ? (cnt_r >> 1) : cnt_r);
        if (len_r && cnt_r[0]) begin
            t_s = sub_word(prev1_r[31:0]);
        end else begin
            t_s = sub_word({prev1_r[23:0], prev1_r[31:24]}) ^ {rcon(rc_idx_s), 24'h0};
        end
        base_s   = len_r ? prev2_r : prev1_r;
        w0_s     = base_s[127:96] ^ t_s;
        w1_s     = base_s[95:64]  ^ w0_s;
        w2_s     = base_s[63:32]  ^ w1_s;
        w3_s     = base_s[31:0]   ^ w2_s;
        new_rk_s = {w0_s, w1_s, w2_s, w3_s};
    end

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: key_init restarts from any state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (key_init) state_nxt_s = ST_GEN;
                else          state_nxt_s = ST_IDLE;
            end
            ST_GEN: begin
                if (key_init)            state_nxt_s = ST_GEN;
                else if (cnt_r == nr_r)  state_nxt_s = ST_DONE;
                else                     state_nxt_s = ST_GEN;
            end
            ST_DONE: begin
                if (key_init) state_nxt_s = ST_GEN;
                else          state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Key latch, per-cycle round-key generation and storage writes.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < MAX_RK; i++) storage_r[i] <= 128'h0;
            prev1_r     <= 128'h0;
            prev2_r     <= 128'h0;
            cnt_r       <= RK_IDX_W'(0);
            nr_r        <= RK_IDX_W'(0);
            len_r       <= 1'b0;
            key_ready_r <= 1'b0;
        end else if (key_init) begin
            nr_r         <= keylen ? RK_IDX_W'(14) : RK_IDX_W'(10);
            len_r        <= keylen;
            storage_r[0] <= key[255:128];
            if (keylen) storage_r[1] <= key[127:0];
            prev2_r      <= key[255:128];
            prev1_r      <= keylen ? key[127:0] : key[255:128];
            cnt_r        <= keylen ? RK_IDX_W'(2) : RK_IDX_W'(1);
            key_ready_r  <= 1'b0;
        end else if (state_r == ST_GEN) begin
            storage_r[cnt_r] <= new_rk_s;
            prev2_r          <= prev1_r;
            prev1_r          <= new_rk_s;
            if (cnt_r == nr_r) key_ready_r <= 1'b1;
            else               cnt_r       <= cnt_r + RK_IDX_W'(1);
        end
    end

    // Gated combinational read of the round-key file.
    always_comb begin
        if (key_ready_r && (round <= nr_r)) begin
            round_key = storage_r[round];
        end else begin
            round_key = 128'h0;
        end
    end

    assign key_ready  = key_ready_r;
    assign num_rounds = nr_r;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Scoreboard bench for aes_key_expansion using FIPS-197 key-schedule vectors.
module tb_aes_key_expansion;

    localparam int K_RK = 0;
    localparam int K_KR = 1;
    localparam int K_NR = 2;

    localparam logic [255:0] KEY_C1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_FIP = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY_256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         aclk;
    logic         aresetn;
    logic         key_init;
    logic         keylen;
    logic [255:0] key;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         key_ready;
    logic [3:0]   num_rounds;

    int           checks;
    int           errors;
    int           q_kind [$];
    logic [127:0] q_exp [$];
    string        q_name [$];

    aes_key_expansion dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .key_init   (key_init),
        .keylen     (keylen),
        .key        (key),
        .round      (round),
        .round_key  (round_key),
        .key_ready  (key_ready),
        .num_rounds (num_rounds)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: pops one expectation per cycle and compares on the falling edge.
    always @(negedge aclk) begin
        if (q_kind.size() > 0) begin
            int           k;
            logic [127:0] e;
            logic [127:0] a;
            string        n;
            k = q_kind.pop_front();
            e = q_exp.pop_front();
            n = q_name.pop_front();
            case (k)
                K_RK:    a = round_key;
                K_KR:    a = {127'h0, key_ready};
                default: a = {124'h0, num_rounds};
            endcase
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h (round=%0d)", n, a, e, round);
            end
        end
    end

    // Advance one cycle, drop key_init, scramble key, push one expectation.
    task automatic chk(input int kind, input logic [3:0] r, input logic [127:0] exp, input string name);
        @(posedge aclk);
        #1;
        key_init = 1'b0;
        key      = ~key;
        keylen   = ~keylen;
        round    = r;
        q_kind.push_back(kind);
        q_exp.push_back(exp);
        q_name.push_back(name);
    endtask

    task automatic pulse_init(input logic kl, input logic [255:0] k);
        @(posedge aclk);
        #1;
        key_init = 1'b1;
        keylen   = kl;
        key      = k;
    endtask

    task automatic do_reset(input logic with_init);
        @(posedge aclk);
        #1;
        aresetn  = 1'b0;
        key_init = with_init;
        keylen   = 1'b1;
        key      = KEY_256;
        @(posedge aclk);
        @(posedge aclk);
        #1;
        aresetn  = 1'b1;
        key_init = 1'b0;
    endtask

    task automatic ready_timing(input int n, input string name);
        for (int i = 0; i <= n; i++) chk(K_KR, 4'd0, {127'h0, (i == n)}, name);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        aresetn  = 1'b0;
        key_init = 1'b0;
        keylen   = 1'b0;
        key      = 256'h0;
        round    = 4'd0;

        do_reset(1'b1);
        chk(K_KR, 4'd0, 128'h0, "reset_key_ready");
        chk(K_NR, 4'd0, 128'h0, "reset_num_rounds");
        for (int r = 0; r < 16; r++) chk(K_RK, 4'(r), 128'h0, "reset_round_key");

        pulse_init(1'b0, KEY_C1);
        ready_timing(10, "aes128_ready_timing");
        chk(K_RK, 4'd0,  128'h000102030405060708090a0b0c0d0e0f, "aes128_rk0");
        chk(K_RK, 4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "aes128_rk1");
        chk(K_RK, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "aes128_rk10");
        chk(K_RK, 4'd11, 128'h0, "aes128_rk11_zero");
        chk(K_NR, 4'd0,  128'd10, "aes128_num_rounds");

        pulse_init(1'b0, KEY_FIP);
        ready_timing(10, "fips128_ready_timing");
        chk(K_RK, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "fips128_rk1");
        chk(K_RK, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips128_rk10");
        chk(K_NR, 4'd0,  128'd10, "fips128_num_rounds");

        pulse_init(1'b1, KEY_256);
        ready_timing(13, "aes256_ready_timing");
        chk(K_NR, 4'd0,  128'd14, "aes256_num_rounds");
        chk(K_RK, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781, "aes256_rk0");
        chk(K_RK, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4, "aes256_rk1");
        chk(K_RK, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde, "aes256_rk2");
        chk(K_RK, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "aes256_rk14");
        chk(K_RK, 4'd15, 128'h0, "aes256_rk15_zero");

        // Restart an AES-256 expansion with an AES-128 key after 5 GEN cycles.
        pulse_init(1'b1, KEY_256);
        for (int i = 0; i < 5; i++) chk(K_KR, 4'd0, 128'h0, "restart_pre_ready");
        pulse_init(1'b0, KEY_FIP);
        ready_timing(10, "restart_ready_timing");
        chk(K_NR, 4'd0,  128'd10, "restart_num_rounds");
        chk(K_RK, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "restart_rk10");
        for (int r = 11; r < 15; r++) chk(K_RK, 4'(r), 128'h0, "restart_high_zero");

        // Reset in the middle of generation.
        pulse_init(1'b0, KEY_C1);
        for (int i = 0; i < 4; i++) chk(K_KR, 4'd0, 128'h0, "midgen_pre_ready");
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        q_kind.push_back(K_KR); q_exp.push_back(128'h0); q_name.push_back("midgen_reset_ready");
        chk(K_RK, 4'd0, 128'h0, "midgen_reset_rk0");
        chk(K_NR, 4'd0, 128'h0, "midgen_reset_num_rounds");
        pulse_init(1'b0, KEY_C1);
        ready_timing(10, "post_reset_ready_timing");
        chk(K_RK, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "post_reset_rk10");

        @(posedge aclk);
        @(posedge aclk);
        #1;
        if (q_kind.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_kind.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
